// File: rtl/seq_sched_pkg.sv
// Shared types and width helpers for the time-shared "1011" detector scheduler.
package seq_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Width of a match counter able to hold 0..width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Width of a channel id; a single channel still gets a 1-bit id.
  function automatic int unsigned id_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [id_w(NCH)-1:0]   ptr,
  output logic [NCH-1:0]         gnt_c,
  output logic [id_w(NCH)-1:0]   id_c,
  output logic                   valid_c
);

  localparam int unsigned ID_W = id_w(NCH);

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned idx;
    gnt_c   = '0;
    id_c    = '0;
    valid_c = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(ptr) + i) % NCH;
      if (!valid_c && req[ID_W'(idx)]) begin
        valid_c            = 1'b1;
        gnt_c[ID_W'(idx)]  = 1'b1;
        id_c               = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one external "1011" Moore detector among NCH channels.
// Optional feature macro: SEQ_SCHED_FIRST_HIT_EN adds first_hit / hit_any.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NCH-1:0]              req,
  input  logic [NCH*WIDTH-1:0]        data,
  output logic [NCH-1:0]              grant,
  output logic                        seq_out,
  output logic                        det_clr,
  input  logic                        det_in,
  output logic                        busy,
  output logic                        done,
  output logic [id_w(NCH)-1:0]        done_ch,
  output logic [cnt_w(WIDTH)-1:0]     match_cnt
`ifdef SEQ_SCHED_FIRST_HIT_EN
  ,
  output logic [$clog2(WIDTH)-1:0]    first_hit,
  output logic                        hit_any
`endif
);

  localparam int unsigned ID_W  = id_w(NCH);
  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam int unsigned BIT_W = $clog2(WIDTH);

  state_e               state_q;
  logic [NCH-1:0]       grant_q;
  logic                 seq_out_q;
  logic                 det_clr_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ID_W-1:0]      id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [WIDTH-1:0]     sh_q;
  logic [BIT_W-1:0]     bit_cnt_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  logic [BIT_W-1:0]     first_hit_q;
  logic                 hit_any_q;
`endif

  logic [ID_W-1:0]      ptr_nxt_c;
  logic [ID_W-1:0]      arb_ptr_c;
  logic [NCH-1:0]       arb_gnt_c;
  logic [ID_W-1:0]      arb_id_c;
  logic                 arb_valid_c;
  logic [WIDTH-1:0]     arb_word_c;
  logic                 cnt_sat_c;

  // Pointer past the job being reported; REPORT arbitrates with it so a
  // waiting channel is granted on the very next cycle.
  assign ptr_nxt_c = (id_q == ID_W'(NCH - 1)) ? '0 : id_q + ID_W'(1);
  assign arb_ptr_c = (state_q == ST_REPORT) ? ptr_nxt_c : rr_ptr_q;
  assign cnt_sat_c = (cnt_q == CNT_W'(WIDTH));

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req),
    .ptr     (arb_ptr_c),
    .gnt_c   (arb_gnt_c),
    .id_c    (arb_id_c),
    .valid_c (arb_valid_c)
  );

  // Select the granted channel's word.
  always_comb begin
    arb_word_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_gnt_c[i]) arb_word_c |= data[i*WIDTH +: WIDTH];
    end
  end

  // Scheduler FSM with registered outputs, shift register and match counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      seq_out_q   <= 1'b0;
      det_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
      first_hit_q <= '0;
      hit_any_q   <= 1'b0;
`endif
    end else begin
      grant_q   <= '0;
      det_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_REPORT: begin
          if (state_q == ST_REPORT) rr_ptr_q <= ptr_nxt_c;
          if (arb_valid_c) begin
            grant_q     <= arb_gnt_c;
            sh_q        <= arb_word_c;
            id_q        <= arb_id_c;
            cnt_q       <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            first_hit_q <= '0;
            hit_any_q   <= 1'b0;
`endif
            det_clr_q   <= 1'b1;
            seq_out_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_CLEAR;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          seq_out_q <= sh_q[WIDTH-1];
          sh_q      <= {sh_q[WIDTH-2:0], 1'b0};
          bit_cnt_q <= '0;
          state_q   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // det_in now reflects bit k-1; bit 0 has no result yet.
          if (bit_cnt_q != '0 && det_in) begin
            if (!cnt_sat_c) cnt_q <= cnt_q + CNT_W'(1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
            if (!hit_any_q) first_hit_q <= bit_cnt_q - BIT_W'(1);
            hit_any_q <= 1'b1;
`endif
          end
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            seq_out_q <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= ST_DRAIN;
          end else begin
            seq_out_q <= sh_q[WIDTH-1];
            sh_q      <= {sh_q[WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        ST_DRAIN: begin
          // Result of the last bit arrives one cycle late.
          if (det_in) begin
            if (!cnt_sat_c) cnt_q <= cnt_q + CNT_W'(1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
            if (!hit_any_q) first_hit_q <= BIT_W'(WIDTH - 1);
            hit_any_q <= 1'b1;
`endif
          end
          done_q  <= 1'b1;
          state_q <= ST_REPORT;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign seq_out   = seq_out_q;
  assign det_clr   = det_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_ch   = id_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  assign first_hit = first_hit_q;
  assign hit_any   = hit_any_q;
`endif

endmodule
